// File: rtl/reg_writeback.sv
// Write-back buffer ahead of the register file write port: two producers feed
// an in-order FIFO that drains one write per cycle, with a pending-write lookup.
module reg_writeback #(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_addr,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [4:0]  mem_addr,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  output logic        enc,
  output logic [4:0]  addrc,
  output logic [31:0] datac,
  input  logic [4:0]  fwd_addr,
  output logic        fwd_hit,
  output logic [31:0] fwd_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] alu_slot;
  logic [CW-1:0] count;
  logic [CW-1:0] free;
  logic          push_mem;
  logic          push_alu;
  logic          pop;

  // Readiness looks only at the registered occupancy, never at this cycle's pop.
  assign free      = CW'(DEPTH) - count;
  assign mem_ready = reset && (free != '0);
  assign alu_ready = reset && ((free >= CW'(2)) || ((free == CW'(1)) && !mem_valid));

  // Register 0 writes complete the handshake but are dropped here.
  assign push_mem = mem_valid && mem_ready && (mem_addr != 5'd0);
  assign push_alu = alu_valid && alu_ready && (alu_addr != 5'd0);
  assign pop      = (count != '0);
  assign alu_slot = wr_ptr + AW'(push_mem);

  always_ff @(posedge clock) begin
    if (push_mem) begin
      addr_q[wr_ptr] <= mem_addr;
      data_q[wr_ptr] <= mem_data;
    end
    if (push_alu) begin
      addr_q[alu_slot] <= alu_addr;
      data_q[alu_slot] <= alu_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      enc    <= 1'b0;
      addrc  <= '0;
      datac  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push_mem) + AW'(push_alu);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + CW'(push_mem) + CW'(push_alu) - CW'(pop);
      enc    <= pop;
      if (pop) begin
        addrc <= addr_q[rd_ptr];
        datac <= data_q[rd_ptr];
      end
    end
  end

  // Walk from oldest to newest so the youngest match overwrites earlier ones.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (reset && (fwd_addr != 5'd0)) begin
      if (enc && (addrc == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = datac;
      end
      for (int j = 0; j < DEPTH; j++) begin
        if ((CW'(j) < count) && (addr_q[rd_ptr + AW'(j)] == fwd_addr)) begin
          fwd_hit  = 1'b1;
          fwd_data = data_q[rd_ptr + AW'(j)];
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: a queue scoreboard tracks accepted writes
// and the expected output register, checked around every clock edge.
module tb_reg_writeback;

  localparam int DEPTH = 4;

  logic        clock;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_addr;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        enc;
  logic [4:0]  addrc;
  logic [31:0] datac;
  logic [4:0]  fwd_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;

  reg_writeback #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .enc(enc), .addrc(addrc), .datac(datac),
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        sb[$];
  logic        m_enc;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, check combinational outputs, clock, check registers.
  task automatic step(input logic rst, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                      input logic mv, input logic [4:0] ma, input logic [31:0] md,
                      input logic [4:0] fa);
    int          free;
    logic        e_mrdy, e_ardy, e_hit, do_pop;
    logic [31:0] e_fd;
    ent_t        e;
    reset = rst; alu_valid = av; alu_addr = aa; alu_data = ad;
    mem_valid = mv; mem_addr = ma; mem_data = md; fwd_addr = fa;
    #1;
    free   = DEPTH - sb.size();
    e_mrdy = rst && (free >= 1);
    e_ardy = rst && ((free >= 2) || (free == 1 && !mv));
    e_hit  = 1'b0;
    e_fd   = 32'd0;
    if (rst && fa != 5'd0) begin
      if (m_enc && m_addr == fa) begin e_hit = 1'b1; e_fd = m_data; end
      foreach (sb[i]) if (sb[i].a == fa) begin e_hit = 1'b1; e_fd = sb[i].d; end
    end
    chk("mem_ready", 32'(mem_ready), 32'(e_mrdy));
    chk("alu_ready", 32'(alu_ready), 32'(e_ardy));
    chk("fwd_hit", 32'(fwd_hit), 32'(e_hit));
    chk("fwd_data", fwd_data, e_fd);
    if (!rst) begin
      sb.delete();
      m_enc = 1'b0; m_addr = '0; m_data = '0;
    end else begin
      do_pop = (sb.size() > 0);
      if (do_pop) begin
        e = sb.pop_front();
        m_addr = e.a; m_data = e.d;
      end
      m_enc = do_pop;
      if (mv && e_mrdy && ma != 5'd0) sb.push_back('{a: ma, d: md});
      if (av && e_ardy && aa != 5'd0) sb.push_back('{a: aa, d: ad});
    end
    @(posedge clock);
    #1;
    chk("enc", 32'(enc), 32'(m_enc));
    chk("addrc", 32'(addrc), 32'(m_addr));
    chk("datac", datac, m_data);
    @(negedge clock);
  endtask

  task automatic idle(input int n, input logic [4:0] fa);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, fa);
  endtask

  initial begin
    m_enc = 1'b0; m_addr = '0; m_data = '0;

    // reset held two edges with both producers offering
    step(1'b0, 1'b1, 5'd1, 32'h0000_0101, 1'b1, 5'd2, 32'h0000_0202, 5'd1);
    step(1'b0, 1'b1, 5'd1, 32'h0000_0101, 1'b1, 5'd2, 32'h0000_0202, 5'd2);
    idle(3, 5'd1);

    // single ALU write
    step(1'b1, 1'b1, 5'd5, 32'h0000_00AA, 1'b0, 5'd0, 32'd0, 5'd5);
    idle(3, 5'd5);

    // same-edge push: mem entry is older
    step(1'b1, 1'b1, 5'd4, 32'h0000_0022, 1'b1, 5'd3, 32'h0000_0011, 5'd3);
    idle(4, 5'd4);

    // backpressure: both producers valid every cycle
    for (int i = 0; i < 14; i++)
      step(1'b1, 1'b1, 5'((2 * i) % 31 + 1), 32'hA000_0000 + 32'(i),
           1'b1, 5'((2 * i + 1) % 31 + 1), 32'hB000_0000 + 32'(i), 5'((i % 8) + 1));
    idle(8, 5'd3);

    // register 0 is handshaken but discarded
    step(1'b1, 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 5'd0);
    idle(3, 5'd0);
    step(1'b1, 1'b1, 5'd0, 32'h1234_5678, 1'b1, 5'd0, 32'h8765_4321, 5'd0);
    idle(2, 5'd0);

    // forwarding: youngest pending r7 wins
    step(1'b1, 1'b1, 5'd7, 32'h0000_0001, 1'b0, 5'd0, 32'd0, 5'd7);
    step(1'b1, 1'b1, 5'd7, 32'h0000_0002, 1'b0, 5'd0, 32'd0, 5'd7);
    idle(3, 5'd7);

    // mid-operation reset with three entries pending
    step(1'b1, 1'b1, 5'd10, 32'h0000_0A0A, 1'b1, 5'd11, 32'h0000_0B0B, 5'd10);
    step(1'b1, 1'b1, 5'd12, 32'h0000_0C0C, 1'b1, 5'd13, 32'h0000_0D0D, 5'd12);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd13);
    idle(5, 5'd12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_writeback.md
# reg_writeback

Write-back buffer sitting directly upstream of the register file's write port. Accepts completed results from two producers (ALU and memory-load path) over valid/ready handshakes, queues them in a small in-order FIFO, and drives the register file's `enc`/`addrc`/`datac` write port at one write per cycle. Also provides a forwarding lookup so operand fetch can see results that are still pending.

## Interface
- `DEPTH`, 4, FIFO entries; power of two, at least 2
- `clock`  in  1  sole clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-low; sampled on rising edge of `clock`
- `alu_valid`  in  1  ALU result offered
- `alu_addr`  in  5  ALU destination register
- `alu_data`  in  32  ALU result
- `alu_ready`  out  1  ALU result accepted this cycle if `alu_valid`
- `mem_valid`  in  1  load result offered
- `mem_addr`  in  5  load destination register
- `mem_data`  in  32  load result
- `mem_ready`  out  1  load result accepted this cycle if `mem_valid`
- `enc`  out  1  register-file write enable (registered)
- `addrc`  out  5  register-file write address (registered)
- `datac`  out  32  register-file write data (registered)
- `fwd_addr`  in  5  forwarding lookup address
- `fwd_hit`  out  1  a pending write to `fwd_addr` exists (combinational)
- `fwd_data`  out  32  data of youngest pending write to `fwd_addr` (combinational)

## Operation
- State: circular FIFO of `DEPTH` {addr, data} entries, read/write pointers, `count` (0..DEPTH), output register {enc, addrc, datac}.
- Reset (`reset`=0 at an edge): `count`=0, pointers=0, `enc`=0, `addrc`=0, `datac`=0; FIFO contents are don't-care. During reset cycles `alu_ready`=`mem_ready`=0 and `fwd_hit`=0.
- Readiness is based on `count` only, not the same-cycle pop: `free` = DEPTH − `count`.
  - `mem_ready` = (`free` ≥ 1).
  - `alu_ready` = (`free` ≥ 2) or (`free` = 1 and not `mem_valid`).
- Transfer occurs when valid and ready are both 1. Up to two pushes per edge; when both transfer, the mem entry is written first (older), the ALU entry second.
- Writes to register 0 are handshaken normally but discarded: never enqueued, never on `enc`, never forwarded.
- Pop: at each edge, if `count` > 0, the head moves into the output register with `enc`=1; otherwise `enc` is set to 0. `addrc`/`datac` keep their last values when `enc`=0.
- `count` next = `count` + pushes − pop; it never exceeds DEPTH, guaranteed by the readiness rules.
- Pointers wrap modulo DEPTH.
- Forwarding searches all valid FIFO entries plus the output register while `enc`=1.
  - Youngest match wins. Age order: newest FIFO entry first, then older FIFO entries, then the output register.
  - `fwd_addr`=0 never hits. On a miss, `fwd_data`=0.
  - Entries being pushed in the current cycle are not visible until the next cycle.

## Timing
- Latency: an entry pushed at edge k, into an empty FIFO, is popped at edge k+1. `enc`=1 with its address and data during the cycle after edge k+1, and the register file commits it at edge k+2.
- Sustained throughput is 1 write/cycle. Bursts of 2 pushes per cycle are absorbed until the FIFO fills.
- Simultaneous push and pop while full: the readiness rules block the push, even though a pop occurs that edge (by design; no combinational ready-from-pop path).
- A reset asserted mid-operation drops all pending entries. `enc` is 0 from the first edge that samples reset low.

## Test plan
- Reset: hold `reset`=0 for 2 edges with both producers valid → `enc`=0, `addrc`=0, `datac`=0, both readies 0, `fwd_hit`=0; no writes occur after release until new pushes.
- Single write: ALU pushes r5=0x0000_00AA at edge k → `enc`=1, `addrc`=5, `datac`=0xAA in the cycle after edge k+1; `enc`=0 the following cycle.
- Ordering: mem r3=0x11 and ALU r4=0x22 pushed on the same edge → `enc` cycles show r3/0x11, then r4/0x22, on consecutive cycles.
- Backpressure (DEPTH=4): both producers valid every cycle with nonzero addresses → `count` never exceeds 4; `alu_ready`=0 whenever `free`<2 and `mem_valid`=1; every accepted entry appears on `enc` exactly once, in order, with none lost or duplicated.
- Register 0 and forwarding:
  - ALU push to r0 → handshake completes, nothing appears on `enc`, and `fwd_addr`=0 gives `fwd_hit`=0.
  - Pending r7=0x1, then r7=0x2 → `fwd_addr`=7 gives `fwd_hit`=1, `fwd_data`=0x2.
- Mid-operation reset: fill FIFO with 3 entries, assert `reset`=0 for one edge → `enc`=0 from that edge; none of the 3 entries is ever written.
